// File: rtl/park_occupancy_monitor_if.sv
// Sensor-in / display-out bundle of the parking occupancy monitor.
// The bench or board top drives SW; the monitor drives everything else.
interface park_occupancy_monitor_if #(
   parameter int unsigned N_SLOTS = 6
);
   logic [N_SLOTS-1:0] SW;
   logic [2:0]         LED;
   logic [6:0]         HEX0;
   logic [6:0]         HEX1;
   logic [6:0]         FREE_COUNT;
   logic               EVT_ENTRY;
   logic               EVT_EXIT;

   modport master (
      output SW,
      input  LED, HEX0, HEX1, FREE_COUNT, EVT_ENTRY, EVT_EXIT
   );

   modport slave (
      input  SW,
      output LED, HEX0, HEX1, FREE_COUNT, EVT_ENTRY, EVT_EXIT
   );
endinterface

// File: rtl/park_occupancy_monitor.sv
// Parking-lot occupancy monitor: per-slot sync/debounce, free-slot count,
// entry/exit pulses, status LEDs with FULL blink and a two-digit 7-seg readout.
module park_occupancy_monitor #(
   parameter int unsigned N_SLOTS         = 6,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned BLINK_CYCLES    = 12500000,
   parameter int unsigned LOW_THRESH      = 1
) (
   input  logic                   CLOCK_50,
   input  logic                   RESET_N,
   park_occupancy_monitor_if.slave bus
);
   localparam int unsigned CNT_W = 7;
   localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned BL_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_CYCLES - 1);
   localparam logic [CNT_W-1:0] FREE_RST = CNT_W'(N_SLOTS);
   localparam logic [CNT_W-1:0] LOW_LIM  = CNT_W'(LOW_THRESH);

   // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   // Returns {HEX1, HEX0}; leading zero in the tens position is blanked.
   function automatic logic [13:0] hex_pair(input logic [CNT_W-1:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens     = 4'(v / CNT_W'(10));
      ones     = 4'(v % CNT_W'(10));
      hex_pair = {((tens == 4'd0) ? 7'h7F : seg7(tens)), seg7(ones)};
   endfunction

   localparam logic [13:0] HEX_RST = hex_pair(FREE_RST);

   typedef enum logic [1:0] {
      ST_AVAIL,
      ST_LOW,
      ST_FULL
   } state_t;

   logic [N_SLOTS-1:0] sync1_q, sync2_q;
   logic [N_SLOTS-1:0] stable_q, stable_d;
   logic [N_SLOTS-1:0] prev_q;
   logic [DB_W-1:0]    db_cnt_q [N_SLOTS];
   logic [DB_W-1:0]    db_cnt_d [N_SLOTS];
   logic [CNT_W-1:0]   occ_c;
   logic [CNT_W-1:0]   free_q;
   logic               evt_entry_q, evt_exit_q;
   state_t             state_q, state_d;
   logic [BL_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic               blink_ph_q, blink_ph_d;
   logic [2:0]         led_q, led_d;
   logic [13:0]        hex_q;

   // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      occ_c = '0;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
         occ_c = occ_c + CNT_W'(stable_q[i]);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         stable_q    <= '0;
         prev_q      <= '0;
         free_q      <= FREE_RST;
         evt_entry_q <= 1'b0;
         evt_exit_q  <= 1'b0;
         for (int i = 0; i < int'(N_SLOTS); i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q     <= bus.SW;
         sync2_q     <= sync1_q;
         stable_q    <= stable_d;
         prev_q      <= stable_q;
         free_q      <= FREE_RST - occ_c;
         evt_entry_q <= |(stable_q & ~prev_q);
         evt_exit_q  <= |(~stable_q & prev_q);
         for (int i = 0; i < int'(N_SLOTS); i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   // Status FSM and blink phase; LED pattern follows the next state.
   always_comb begin
      state_d     = ST_AVAIL;
      blink_cnt_d = '0;
      blink_ph_d  = blink_ph_q;
      led_d       = 3'b001;

      if (free_q == '0) begin
         state_d = ST_FULL;
      end else if (free_q <= LOW_LIM) begin
         state_d = ST_LOW;
      end

      case (state_d)
         ST_FULL: begin
            if (state_q != ST_FULL) begin
               blink_ph_d = 1'b1;
            end else if (blink_cnt_q == BL_LAST) begin
               blink_ph_d = ~blink_ph_q;
            end else begin
               blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
            led_d = {1'b0, blink_ph_d, 1'b0};
         end
         ST_LOW:  led_d = 3'b100;
         default: led_d = 3'b001;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_AVAIL;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         led_q       <= 3'b001;
         hex_q       <= HEX_RST;
      end else begin
         state_q     <= state_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         led_q       <= led_d;
         hex_q       <= hex_pair(free_q);
      end
   end

   assign bus.FREE_COUNT = free_q;
   assign bus.EVT_ENTRY  = evt_entry_q;
   assign bus.EVT_EXIT   = evt_exit_q;
   assign bus.LED        = led_q;
   assign bus.HEX0       = hex_q[6:0];
   assign bus.HEX1       = hex_q[13:7];

endmodule

// File: tb/tb_park_occupancy_monitor.sv
// Bench for park_occupancy_monitor: directed scenarios plus random sensor
// activity, every clock compared against a sample-history reference model.
module tb_park_occupancy_monitor;
   localparam int unsigned N  = 12;
   localparam int unsigned DB = 4;
   localparam int unsigned BL = 8;
   localparam int unsigned LT = 2;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] sw    = '0;

   always #5 clk = ~clk;

   park_occupancy_monitor_if #(.N_SLOTS(N)) pif ();
   assign pif.SW = sw;

   park_occupancy_monitor #(
      .N_SLOTS        (N),
      .DEBOUNCE_CYCLES(DB),
      .BLINK_CYCLES   (BL),
      .LOW_THRESH     (LT)
   ) dut (
      .CLOCK_50(clk),
      .RESET_N (rst_n),
      .bus     (pif)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Reference model: a slot's accepted state becomes the raw value once the
   // last DB samples, seen two clocks late, all agree and differ from it.
   logic [6:0]   seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [N-1:0] hist [$];
   logic [N-1:0] m_stable, m_prev;
   int           m_free;
   int           m_age;
   logic         m_en, m_ex;
   logic [2:0]   m_led;
   logic [6:0]   m_hex0, m_hex1;

   function automatic void set_hex(input int v);
      m_hex0 = seg_tab[v % 10];
      m_hex1 = ((v / 10) == 0) ? 7'h7F : seg_tab[v / 10];
   endfunction

   function automatic void model_reset();
      hist.delete();
      for (int k = 0; k < int'(DB) + 2; k++) hist.push_back('0);
      m_stable = '0;
      m_prev   = '0;
      m_free   = int'(N);
      m_age    = -1;
      m_en     = 1'b0;
      m_ex     = 1'b0;
      m_led    = 3'b001;
      set_hex(int'(N));
   endfunction

   function automatic void model_step();
      logic agree;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_free == 0) begin
         m_age = (m_age < 0) ? 0 : m_age + 1;
         m_led = {1'b0, (((m_age / int'(BL)) % 2) == 0), 1'b0};
      end else begin
         m_age = -1;
         m_led = (m_free <= int'(LT)) ? 3'b100 : 3'b001;
      end
      set_hex(m_free);
      m_en   = |(m_stable & ~m_prev);
      m_ex   = |(~m_stable & m_prev);
      m_prev = m_stable;
      m_free = int'(N) - $countones(m_stable);
      hist.push_front(sw);
      void'(hist.pop_back());
      for (int b = 0; b < int'(N); b++) begin
         agree = 1'b1;
         for (int k = 3; k < int'(DB) + 2; k++)
            if (hist[k][b] != hist[2][b]) agree = 1'b0;
         if (agree && (hist[2][b] != m_stable[b])) m_stable[b] = hist[2][b];
      end
   endfunction

   task automatic check_all();
      chk("free_count", 32'(pif.FREE_COUNT), 32'(m_free));
      chk("evt_entry",  32'(pif.EVT_ENTRY),  32'(m_en));
      chk("evt_exit",   32'(pif.EVT_EXIT),   32'(m_ex));
      chk("led",        32'(pif.LED),        32'(m_led));
      chk("hex0",       32'(pif.HEX0),       32'(m_hex0));
      chk("hex1",       32'(pif.HEX1),       32'(m_hex1));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Called 1 time unit after a rising edge; asserts reset between edges.
   task automatic apply_reset(input int hold, input logic [N-1:0] sw_during);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_led_now",  32'(pif.LED),        32'(3'b001));
      chk("rst_free_now", 32'(pif.FREE_COUNT), 32'(N));
      check_all();
      sw = sw_during;
      repeat (hold) tick();
      #3 rst_n = 1'b1;
   endtask

   int pulses, lat, toggles, both_seen;
   logic prev_blink;

   initial begin
      model_reset();
      repeat (3) tick();
      chk("rst_hex1", 32'(pif.HEX1), 32'(7'h79));
      chk("rst_hex0", 32'(pif.HEX0), 32'(7'h24));
      #3 rst_n = 1'b1;

      // Short glitch must be rejected.
      sw[0] = 1'b1;
      repeat (3) tick();
      sw[0] = 1'b0;
      pulses = 0;
      repeat (10) begin tick(); if (pif.EVT_ENTRY) pulses++; end
      chk("bounce_pulses", 32'(pulses), 32'd0);
      chk("bounce_free", 32'(pif.FREE_COUNT), 32'd12);

      // Held change: one pulse, seven clocks after the edge.
      sw[0] = 1'b1;
      pulses = 0; lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (pif.EVT_ENTRY) begin pulses++; lat = i; end
      end
      chk("hold_pulses", 32'(pulses), 32'd1);
      chk("hold_latency", 32'(lat), 32'd7);
      chk("hold_free", 32'(pif.FREE_COUNT), 32'd11);

      // Nine slots settle together.
      sw = 12'h3FF;
      pulses = 0;
      repeat (10) begin tick(); if (pif.EVT_ENTRY) pulses++; end
      chk("multi_pulses", 32'(pulses), 32'd1);
      chk("multi_free", 32'(pif.FREE_COUNT), 32'd2);
      chk("multi_hex1", 32'(pif.HEX1), 32'(7'h7F));
      chk("multi_hex0", 32'(pif.HEX0), 32'(7'h24));
      chk("multi_led", 32'(pif.LED), 32'(3'b100));

      // Fill up and watch the blink.
      sw = 12'hFFF;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         tick();
         if (pif.FREE_COUNT == 7'd0) lat = i;
      end
      chk("full_reached", 32'(lat), 32'd7);
      tick();
      chk("full_first_led", 32'(pif.LED), 32'(3'b010));
      toggles = 0;
      prev_blink = pif.LED[1];
      repeat (32) begin
         tick();
         if (pif.LED[1] != prev_blink) toggles++;
         prev_blink = pif.LED[1];
         chk("full_side_leds", 32'({pif.LED[2], pif.LED[0]}), 32'd0);
      end
      chk("blink_toggles", 32'(toggles), 32'd4);

      // One slot leaves.
      sw[11] = 1'b0;
      pulses = 0;
      repeat (10) begin tick(); if (pif.EVT_EXIT) pulses++; end
      chk("exit_pulses", 32'(pulses), 32'd1);
      chk("exit_free", 32'(pif.FREE_COUNT), 32'd1);
      chk("exit_led", 32'(pif.LED), 32'(3'b100));

      // Simultaneous swap.
      sw[0] = 1'b0; sw[11] = 1'b1;
      both_seen = 0;
      repeat (10) begin tick(); if (pif.EVT_ENTRY && pif.EVT_EXIT) both_seen++; end
      chk("swap_both", 32'(both_seen), 32'd1);
      chk("swap_free", 32'(pif.FREE_COUNT), 32'd1);

      // Reset mid-blink and mid-debounce.
      sw = 12'hFFF;
      repeat (20) tick();
      sw[0] = 1'b0;
      repeat (2) tick();
      apply_reset(2, 12'hFFF);
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         tick();
         if (pif.FREE_COUNT == 7'd0) lat = i;
      end
      chk("post_rst_full", 32'(lat), 32'd7);

      // Random sensor activity.
      for (int c = 0; c < 1500; c++) begin
         case ($urandom_range(0, 15))
            0:       sw = N'($urandom);
            1:       sw = '1;
            2:       sw = '0;
            3, 4:    sw[$urandom_range(0, N - 1)] ^= 1'b1;
            default: ;
         endcase
         if (c == 700) apply_reset(1, N'($urandom));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
